// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V datapath: FSM states,
// opcodes and mux/ALU/immediate select codes (same values as the main decoder).
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_JAL,
    S_JALR_ADR,
    S_JALR,
    S_BRANCH,
    S_LUI_WB
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_ADDR   = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_controller.sv
// Control FSM sequencing the shared multicycle RISC-V datapath.
// Define MULTICYCLE_MEM_WAIT_EN to add the mem_req/mem_ready memory handshake.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] op,
  input  logic       branch_taken,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic       mem_ready,
  output logic       mem_req,
`endif
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state, next_state;
  logic   ready;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign ready   = mem_ready;
  assign mem_req = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    imm_src    = IMM_I;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    unique case (state)
      S_BOOT: next_state = S_FETCH;
      S_FETCH: begin
        ir_write   = ready;
        pc_write   = ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        next_state = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
        unique case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR_ADR;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_LUI:            next_state = S_LUI_WB;
          default: begin
            illegal_op = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_ADDR;
        imm_src    = (op == OP_STORE) ? IMM_S : IMM_I;
        next_state = (op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        adr_src    = 1'b1;
        next_state = ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        result_src = RES_READDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = ready;
        next_state = ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL, S_JALR: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = S_ALU_WB;
      end
      S_JALR_ADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = S_JALR;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_BRANCH;
        pc_write   = branch_taken;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_LUI_WB: begin
        imm_src    = IMM_U;
        result_src = RES_IMMEXT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_BOOT;
    endcase

    // Stall freezes the state and suppresses every strobe; selects stay state-decoded.
    if (!en) begin
      next_state = state;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected outputs are
// queued with their stimulus and compared as each cycle completes.
module tb_multicycle_controller;

  localparam int T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3, T_MEM_RD = 4, T_MEM_WB = 5,
                 T_MEM_WR = 6, T_EXEC_R = 7, T_EXEC_I = 8, T_ALU_WB = 9, T_JAL = 10,
                 T_JALR_ADR = 11, T_JALR = 12, T_BRANCH = 13, T_LUI_WB = 14;

  localparam logic [6:0] LD = 7'b0000011, STO = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, JL = 7'b1101111, JR = 7'b1100111,
                         BR = 7'b1100011, LU = 7'b0110111, BAD = 7'b1111111;

  typedef struct packed {
    logic       pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0] res, a, b, aluop;
    logic [2:0] imm;
    logic       done, ill;
  } out_t;

  typedef struct {
    int         st;
    logic [6:0] op;
    logic       bt, en, rdy;
  } ent_t;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, branch_taken = 1'b0;
  logic [6:0] op = 7'd0;
  logic pc_write, adr_src, ir_write, mem_write, reg_write, instr_done, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic mem_ready = 1'b1;
  logic mem_req;
`endif

  ent_t q[$];
  int   tests = 0, fails = 0;
  bit   rand_stall = 1'b0;
  out_t act;

  assign act = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal_op};

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .branch_taken(branch_taken),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready(mem_ready), .mem_req(mem_req),
`endif
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  function automatic string sname(int st);
    case (st)
      T_FETCH: return "FETCH";     T_DECODE: return "DECODE";  T_MEMADR: return "MEMADR";
      T_MEM_RD: return "MEM_RD";   T_MEM_WB: return "MEM_WB";  T_MEM_WR: return "MEM_WR";
      T_EXEC_R: return "EXEC_R";   T_EXEC_I: return "EXEC_I";  T_ALU_WB: return "ALU_WB";
      T_JAL: return "JAL";         T_JALR_ADR: return "JALR_ADR"; T_JALR: return "JALR";
      T_BRANCH: return "BRANCH";   T_LUI_WB: return "LUI_WB";
      default: return "?";
    endcase
  endfunction

  function automatic logic legal(logic [6:0] o);
    return (o == LD) || (o == STO) || (o == RT) || (o == IT) || (o == JL) ||
           (o == JR) || (o == BR) || (o == LU);
  endfunction

  // Expected outputs per state, written from the state/output table.
  function automatic out_t model(int st, logic [6:0] o, logic bt, logic e, logic rdy);
    out_t r = '0;
    case (st)
      T_FETCH:    begin r.ir_write = rdy; r.pc_write = rdy; r.b = 2'b10; r.res = 2'b10; end
      T_DECODE:   begin r.a = 2'b01; r.b = 2'b01; r.imm = (o == JL) ? 3'b011 : 3'b010;
                        r.ill = !legal(o); end
      T_MEMADR:   begin r.a = 2'b10; r.b = 2'b01; r.aluop = 2'b11;
                        r.imm = (o == STO) ? 3'b001 : 3'b000; end
      T_MEM_RD:   r.adr_src = 1'b1;
      T_MEM_WB:   begin r.res = 2'b01; r.reg_write = 1'b1; r.done = 1'b1; end
      T_MEM_WR:   begin r.adr_src = 1'b1; r.mem_write = 1'b1; r.done = rdy; end
      T_EXEC_R:   begin r.a = 2'b10; r.aluop = 2'b10; end
      T_EXEC_I:   begin r.a = 2'b10; r.b = 2'b01; r.aluop = 2'b10; end
      T_ALU_WB:   begin r.reg_write = 1'b1; r.done = 1'b1; end
      T_JAL, T_JALR: begin r.a = 2'b01; r.b = 2'b10; r.pc_write = 1'b1; end
      T_JALR_ADR: begin r.a = 2'b10; r.b = 2'b01; end
      T_BRANCH:   begin r.a = 2'b10; r.aluop = 2'b01; r.pc_write = bt; r.done = 1'b1; end
      T_LUI_WB:   begin r.imm = 3'b100; r.res = 2'b11; r.reg_write = 1'b1; r.done = 1'b1; end
      default: ;
    endcase
    if (!e) begin
      r.pc_write = 1'b0; r.ir_write = 1'b0; r.mem_write = 1'b0;
      r.reg_write = 1'b0; r.done = 1'b0; r.ill = 1'b0;
    end
    return r;
  endfunction

  task automatic pushs(int st, logic [6:0] o, logic bt, logic e = 1'b1, logic rdy = 1'b1);
    if (rand_stall && e && ($urandom_range(0, 3) == 0))
      q.push_back('{st, o, bt, 1'b0, rdy});
    q.push_back('{st, o, bt, e, rdy});
  endtask

  task automatic push_instr(logic [6:0] o, logic bt);
    pushs(T_FETCH, o, bt);
    pushs(T_DECODE, o, bt);
    case (o)
      LD:  begin pushs(T_MEMADR, o, bt); pushs(T_MEM_RD, o, bt); pushs(T_MEM_WB, o, bt); end
      STO: begin pushs(T_MEMADR, o, bt); pushs(T_MEM_WR, o, bt); end
      RT:  begin pushs(T_EXEC_R, o, bt); pushs(T_ALU_WB, o, bt); end
      IT:  begin pushs(T_EXEC_I, o, bt); pushs(T_ALU_WB, o, bt); end
      JL:  begin pushs(T_JAL, o, bt); pushs(T_ALU_WB, o, bt); end
      JR:  begin pushs(T_JALR_ADR, o, bt); pushs(T_JALR, o, bt); pushs(T_ALU_WB, o, bt); end
      BR:  pushs(T_BRANCH, o, bt);
      LU:  pushs(T_LUI_WB, o, bt);
      default: ;
    endcase
  endtask

  // Drives one queued cycle and returns its expected and observed outputs.
  task automatic step(output ent_t e, output out_t exp_v, output out_t act_v);
    e = q.pop_front();
    op = e.op; branch_taken = e.bt; en = e.en;
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = e.rdy;
`endif
    @(negedge clk);
    exp_v = model(e.st, e.op, e.bt, e.en, e.rdy);
    act_v = act;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    ent_t e; out_t ev, av;
    @(negedge clk);
    tests++;
    if (act !== 18'd0) begin fails++; $display("FAIL reset_boot: got %h expected %h", act, 18'd0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    pushs(T_FETCH, RT, 1'b0); pushs(T_DECODE, RT, 1'b0);
    while (q.size() > 0) begin
      step(e, ev, av); tests++;
      if (av !== ev) begin fails++; $display("FAIL reset_pre %s: got %h expected %h", sname(e.st), av, ev); end
    end
    #2;
    ev = model(T_EXEC_R, RT, 1'b0, 1'b1, 1'b1);
    tests++;
    if (act !== ev) begin fails++; $display("FAIL mid_exec_r: got %h expected %h", act, ev); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (act !== 18'd0) begin fails++; $display("FAIL async_reset: got %h expected %h", act, 18'd0); end
    @(negedge clk);
    tests++;
    if (act !== 18'd0) begin fails++; $display("FAIL boot_hold: got %h expected %h", act, 18'd0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_instr(LU, 1'b0);
    while (q.size() > 0) begin
      step(e, ev, av); tests++;
      if (av !== ev) begin fails++; $display("FAIL reset_fetch %s: got %h expected %h", sname(e.st), av, ev); end
    end
  endtask

  task automatic test_mem();
    ent_t e; out_t ev, av;
    push_instr(LD, 1'b0); push_instr(STO, 1'b0);
    while (q.size() > 0) begin
      step(e, ev, av); tests++;
      if (av !== ev) begin fails++; $display("FAIL mem %s: got %h expected %h", sname(e.st), av, ev); end
    end
  endtask

  task automatic test_branch();
    ent_t e; out_t ev, av;
    push_instr(BR, 1'b1); push_instr(BR, 1'b0); push_instr(LU, 1'b1);
    while (q.size() > 0) begin
      step(e, ev, av); tests++;
      if (av !== ev) begin fails++; $display("FAIL branch %s bt=%0b: got %h expected %h", sname(e.st), e.bt, av, ev); end
    end
  endtask

  task automatic test_alu_jump();
    ent_t e; out_t ev, av;
    push_instr(RT, 1'b0); push_instr(IT, 1'b0); push_instr(JL, 1'b0);
    push_instr(JR, 1'b0); push_instr(BAD, 1'b0); push_instr(7'd0, 1'b0);
    while (q.size() > 0) begin
      step(e, ev, av); tests++;
      if (av !== ev) begin fails++; $display("FAIL alu_jump %s op=%b: got %h expected %h", sname(e.st), e.op, av, ev); end
    end
  endtask

  task automatic test_stall();
    ent_t e; out_t ev, av;
    int writes = 0;
    pushs(T_FETCH, LD, 1'b0); pushs(T_DECODE, LD, 1'b0);
    pushs(T_MEMADR, LD, 1'b0); pushs(T_MEM_RD, LD, 1'b0);
    for (int i = 0; i < 3; i++) pushs(T_MEM_WB, LD, 1'b0, 1'b0);
    pushs(T_MEM_WB, LD, 1'b0);
    pushs(T_FETCH, RT, 1'b0, 1'b0);
    push_instr(RT, 1'b0);
    while (q.size() > 0) begin
      step(e, ev, av); tests++;
      if (e.st == T_MEM_WB) writes += int'(av.reg_write);
      if (av !== ev) begin fails++; $display("FAIL stall %s en=%0b: got %h expected %h", sname(e.st), e.en, av, ev); end
    end
    tests++;
    if (writes !== 1) begin fails++; $display("FAIL stall_writes: got %0d expected 1", writes); end
  endtask

  task automatic test_back_to_back();
    ent_t e; out_t ev, av;
    logic [6:0] ops [10] = '{LD, STO, RT, IT, JL, JR, BR, LU, BAD, 7'b0000111};
    rand_stall = 1'b1;
    for (int i = 0; i < 24; i++) push_instr(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)));
    rand_stall = 1'b0;
    while (q.size() > 0) begin
      step(e, ev, av); tests++;
      if (av !== ev) begin fails++; $display("FAIL b2b %s op=%b en=%0b: got %h expected %h", sname(e.st), e.op, e.en, av, ev); end
    end
  endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
  task automatic test_mem_wait();
    ent_t e; out_t ev, av;
    logic rq;
    pushs(T_FETCH, STO, 1'b0, 1'b1, 1'b0); pushs(T_FETCH, STO, 1'b0, 1'b1, 1'b0);
    pushs(T_FETCH, STO, 1'b0, 1'b0, 1'b1);
    pushs(T_FETCH, STO, 1'b0); pushs(T_DECODE, STO, 1'b0); pushs(T_MEMADR, STO, 1'b0);
    pushs(T_MEM_WR, STO, 1'b0, 1'b1, 1'b0); pushs(T_MEM_WR, STO, 1'b0);
    pushs(T_FETCH, LD, 1'b0); pushs(T_DECODE, LD, 1'b0); pushs(T_MEMADR, LD, 1'b0);
    pushs(T_MEM_RD, LD, 1'b0, 1'b1, 1'b0); pushs(T_MEM_RD, LD, 1'b0); pushs(T_MEM_WB, LD, 1'b0);
    while (q.size() > 0) begin
      step(e, ev, av);
      rq = (e.st == T_FETCH) || (e.st == T_MEM_RD) || (e.st == T_MEM_WR);
      tests++;
      if (av !== ev) begin fails++; $display("FAIL mem_wait %s rdy=%0b: got %h expected %h", sname(e.st), e.rdy, av, ev); end
      tests++;
      if (mem_req !== rq) begin fails++; $display("FAIL mem_req %s: got %b expected %b", sname(e.st), mem_req, rq); end
    end
    mem_ready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_mem();
    test_branch();
    test_alu_jump();
    test_stall();
`ifdef MULTICYCLE_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

- Moore/Mealy control FSM that sequences the shared multicycle RISC-V datapath: one ALU, one unified instruction/data memory port and one register-file write port.
- Each instruction takes 3–5 cycles.
- Sits beside the datapath. Reads the opcode from the instruction register and the datapath's branch-resolution flag, and drives every mux select and write enable.
- Control encodings match the single-cycle main decoder, so the ALU decoder and immediate extender are reused unchanged.

## Interface

Parameters:
- None. Encodings and states come from the shared package.

Ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 = stall.
- op  in  7  opcode from the instruction register; stable from the cycle after FETCH.
- branch_taken  in  1  datapath branch condition (funct3 applied to flags), valid in BRANCH.
- pc_write  out  1  PC register load.
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  out  1  instruction register (and OldPC) load.
- mem_write  out  1  memory write enable.
- reg_write  out  1  register-file write enable.
- result_src  out  2  Result mux: 00 ALUOut, 01 ReadData, 10 ALUResult, 11 ImmExt.
- alu_src_a  out  2  ALU A input: 00 PC, 01 OldPC, 10 rs1.
- alu_src_b  out  2  ALU B input: 00 rs2, 01 ImmExt, 10 constant 4.
- alu_op  out  2  ALU operation: 00 add, 01 branch compare, 10 funct-decoded, 11 address add.
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- instr_done  out  1  one-cycle pulse in the last cycle of a legal instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.

## Operation

States are listed with their outputs. Unlisted outputs are 0.
- BOOT: reset state.
  - All outputs 0.
  - Next state: FETCH.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, alu_op=00, result_src=10, pc_write=1.
  - Next state: DECODE.
- DECODE: a=01, b=01, alu_op=00, imm_src=011 if op=JAL else 010. ALUOut captures the branch/jump target.
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 1101111 → JAL.
  - 1100111 → JALR_ADR.
  - 1100011 → BRANCH.
  - 0110111 → LUI_WB.
  - Any other opcode → FETCH with illegal_op=1. The PC has already advanced, so the instruction is skipped.
- MEMADR: a=10, b=01, alu_op=11, imm_src=000 for load, 001 for store.
  - Next state: MEM_RD (load) or MEM_WR (store).
- MEM_RD: adr_src=1, result_src=00.
  - Next state: MEM_WB.
- MEM_WB: result_src=01, reg_write=1, instr_done=1.
  - Next state: FETCH.
- MEM_WR: adr_src=1, result_src=00, mem_write=1, instr_done=1.
  - Next state: FETCH.
- EXEC_R: a=10, b=00, alu_op=10.
  - Next state: ALU_WB.
- EXEC_I: a=10, b=01, imm_src=000, alu_op=10.
  - Next state: ALU_WB.
- ALU_WB: result_src=00, reg_write=1, instr_done=1.
  - Next state: FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. PC takes the target; ALUOut takes PC+4.
  - Next state: ALU_WB.
- JALR_ADR: a=10, b=01, imm_src=000, alu_op=00.
  - Next state: JALR.
- JALR: same outputs as JAL. Clearing the target LSB is the datapath's job.
  - Next state: ALU_WB.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=branch_taken (Mealy), instr_done=1.
  - Next state: FETCH.
- LUI_WB: imm_src=100, result_src=11, reg_write=1, instr_done=1.
  - Next state: FETCH.

Stall rules:
- When en=0, the state holds.
- pc_write, ir_write, mem_write, reg_write, instr_done and illegal_op are forced to 0.
- Select outputs keep their state-decoded values.

## Timing

- Reset: asserting rst_n=0 forces BOOT asynchronously at any point, including mid-instruction. All outputs are 0 while in BOOT.
- The first FETCH occurs in the first rising edge after rst_n deasserts plus one cycle.
- Cycles per instruction (FETCH through the last state):
  - Branch and LUI: 3.
  - Store, R-type, I-type and JAL: 4.
  - Load and JALR: 5.
  - Illegal opcode: 2.
- State updates on the rising clk edge. Outputs are combinational from the state, plus op in DECODE/MEMADR and branch_taken in BRANCH. There are no output registers.
- Write enables are high for exactly one cycle per state visit.

## Configuration

- MULTICYCLE_MEM_WAIT_EN defined: adds input mem_ready (1 bit) and output mem_req (1 bit).
  - mem_req=1 in FETCH, MEM_RD and MEM_WR.
  - Those states hold until mem_ready=1.
  - In FETCH, ir_write and pc_write assert only in the mem_ready cycle.
  - In MEM_WR, mem_write stays high through the wait, and instr_done pulses only in the mem_ready cycle.
  - en=0 overrides mem_ready.
- MULTICYCLE_MEM_WAIT_EN undefined: neither port exists and memory is treated as always ready.

## Structure

- Shared package ctrl_pkg holds:
  - The state enum.
  - Opcode localparams.
  - Encodings for result_src, alu_src_a, alu_src_b, alu_op and imm_src.
- The main decoder should migrate to the same constants.
- Implement one state register plus a single next-state/output always_comb. No sub-module is needed.

## Test plan

- Reset → BOOT → FETCH:
  - Assert rst_n=0 mid-EXEC_R: all outputs go 0 immediately.
  - Release: the cycle after the BOOT cycle shows ir_write=1, pc_write=1, b=10.
- Load (op=0000011):
  - State sequence FETCH, DECODE, MEMADR, MEM_RD, MEM_WB.
  - reg_write=1 and result_src=01 only in cycle 5; instr_done pulses once.
- Store (op=0100011):
  - MEMADR shows imm_src=001.
  - mem_write=1 for exactly 1 cycle (cycle 4), then FETCH.
- Branch (op=1100011):
  - With branch_taken=1 in BRANCH: pc_write=1.
  - With branch_taken=0: pc_write=0.
  - Both cases return to FETCH after 3 cycles.
- JAL and illegal opcode:
  - JAL: DECODE shows imm_src=011; JAL state has pc_write=1; ALU_WB has reg_write=1.
  - op=1111111: illegal_op pulses in DECODE, then FETCH, with no reg_write or mem_write.
- Stall:
  - en=0 held 3 cycles in MEM_WB: state is frozen and reg_write=0.
  - Re-enabling performs exactly one write.
  - With MULTICYCLE_MEM_WAIT_EN, mem_ready=0 for 2 cycles in FETCH delays ir_write to the ready cycle.
